// File: rtl/global_branch_predictor_if.sv
// global_branch_predictor_if
//   Groups the fetch/decode signals exchanged between the pipeline and the
//   branch predictor.
//   Signals:
//     pcsrcd     [1:0]  decode outcome (bit0 branch taken, bit1 jump)
//     pcd        [31:0] PC of the instruction in decode
//     pcbranchd  [31:0] actual target of the instruction in decode
//     originalpc [31:0] PC of the instruction being fetched
//     pcnext     [31:0] next fetch address chosen by the predictor
//     clrbp             misprediction flush
//   Modports:
//     master : pipeline side, drives the decode/fetch information
//     slave  : predictor side, returns pcnext and clrbp
interface global_branch_predictor_if;
  logic [1:0]  pcsrcd;
  logic [31:0] pcd;
  logic [31:0] pcbranchd;
  logic [31:0] originalpc;
  logic [31:0] pcnext;
  logic        clrbp;

  modport master (
    output pcsrcd, pcd, pcbranchd, originalpc,
    input  pcnext, clrbp
  );

  modport slave (
    input  pcsrcd, pcd, pcbranchd, originalpc,
    output pcnext, clrbp
  );
endinterface

// File: rtl/global_branch_predictor.sv
// global_branch_predictor
//   Fetch-stage branch predictor: a fully-associative branch target buffer
//   (BTB) with round-robin replacement plus a pattern history table (PHT) of
//   2-bit saturating counters. A global history register (GHR) is always
//   maintained.
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     reset  : asynchronous, active-high reset
//     bp     : global_branch_predictor_if.slave
//              (pcsrcd, pcd, pcbranchd, originalpc in; pcnext, clrbp out)
//   Parameters:
//     BTB_ENTRIES : number of BTB entries (power of 2, >= 2)
//     HIST_BITS   : GHR width; the PHT holds 2^HIST_BITS counters
//     PC_STEP     : sequential PC increment
//   Configuration macro:
//     GBP_GSHARE_EN : when defined the PHT is indexed by pc XOR GHR (gshare);
//                     otherwise by the low PC bits alone (bimodal).
module global_branch_predictor #(
  parameter int BTB_ENTRIES = 8,
  parameter int HIST_BITS   = 6,
  parameter int PC_STEP     = 4
) (
  input logic                       clk,
  input logic                       reset,
  global_branch_predictor_if.slave  bp
);

  localparam int PHT_SIZE = 1 << HIST_BITS;
  localparam int PTR_W    = $clog2(BTB_ENTRIES);
  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic                 btb_valid  [BTB_ENTRIES];
  logic [31:0]          btb_tag    [BTB_ENTRIES];
  logic [31:0]          btb_target [BTB_ENTRIES];
  logic [PTR_W-1:0]     rep_ptr;

  logic [1:0]           pht [PHT_SIZE];
  logic [HIST_BITS-1:0] ghr;
  logic [HIST_BITS-1:0] ghr_next;

  // Record of the prediction made for the instruction now in decode
  logic                 rec_valid;
  logic                 rec_predt;
  logic [31:0]          rec_target;
  logic [HIST_BITS-1:0] rec_idx;

  logic                 fetch_hit;
  logic [31:0]          fetch_target;
  logic [HIST_BITS-1:0] fetch_idx;
  logic                 fetch_predt;
  logic [31:0]          pred_pc;

  logic                 dec_hit;
  logic [PTR_W-1:0]     dec_slot;
  logic                 resolved_taken;
  logic                 mispredict;

  // Fetch-side lookup. Tags are unique because allocation only happens on a
  // miss, so the first match is the only match.
  always_comb begin
    fetch_hit    = 1'b0;
    fetch_target = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (!fetch_hit && btb_valid[i] && (btb_tag[i] == bp.originalpc)) begin
        fetch_hit    = 1'b1;
        fetch_target = btb_target[i];
      end
    end
  end

`ifdef GBP_GSHARE_EN
  assign fetch_idx = bp.originalpc[HIST_BITS-1:0] ^ ghr;
`else
  assign fetch_idx = bp.originalpc[HIST_BITS-1:0];
`endif

  assign fetch_predt = fetch_hit && pht[fetch_idx][1];
  assign pred_pc     = fetch_predt ? fetch_target : (bp.originalpc + STEP);

  // Decode-side lookup, used to pick the entry to retarget and to decide
  // whether a not-taken resolution still trains the PHT.
  always_comb begin
    dec_hit  = 1'b0;
    dec_slot = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (!dec_hit && btb_valid[i] && (btb_tag[i] == bp.pcd)) begin
        dec_hit  = 1'b1;
        dec_slot = PTR_W'(i);
      end
    end
  end

  assign resolved_taken = bp.pcsrcd[0] | bp.pcsrcd[1];

  // A taken/not-taken disagreement, or a taken prediction to the wrong place
  assign mispredict = rec_valid &&
                      ((rec_predt != resolved_taken) ||
                       (resolved_taken && rec_predt && (rec_target != bp.pcbranchd)));

  // The correction for the decode instruction always wins over the new
  // fetch prediction.
  always_comb begin
    bp.clrbp  = mispredict;
    bp.pcnext = pred_pc;
    if (mispredict) begin
      bp.pcnext = resolved_taken ? bp.pcbranchd : (bp.pcd + STEP);
    end
  end

  // Shifting the whole register keeps every GHR bit live even when the
  // bimodal index ignores it.
  assign ghr_next = (ghr << 1) | HIST_BITS'(resolved_taken);

  // BTB allocation / retargeting with a round-robin replacement pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      rep_ptr <= '0;
    end else if (rec_valid && resolved_taken) begin
      if (dec_hit) begin
        btb_target[dec_slot] <= bp.pcbranchd;
      end else begin
        btb_valid[rep_ptr]  <= 1'b1;
        btb_tag[rep_ptr]    <= bp.pcd;
        btb_target[rep_ptr] <= bp.pcbranchd;
        rep_ptr             <= rep_ptr + PTR_W'(1);
      end
    end
  end

  // PHT counter training and history shift. Branches that never entered the
  // BTB and resolve not-taken are treated as ordinary instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) begin
        pht[i] <= 2'b01;
      end
      ghr <= '0;
    end else if (rec_valid && (resolved_taken || dec_hit)) begin
      if (resolved_taken && (pht[rec_idx] != 2'b11)) begin
        pht[rec_idx] <= pht[rec_idx] + 2'b01;
      end else if (!resolved_taken && (pht[rec_idx] != 2'b00)) begin
        pht[rec_idx] <= pht[rec_idx] - 2'b01;
      end
      ghr <= ghr_next;
    end
  end

  // Capture the fetch prediction; a flush squashes the fetched instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_valid  <= 1'b0;
      rec_predt  <= 1'b0;
      rec_target <= '0;
      rec_idx    <= '0;
    end else begin
      rec_valid  <= !mispredict;
      rec_predt  <= fetch_predt;
      rec_target <= fetch_target;
      rec_idx    <= fetch_idx;
    end
  end

endmodule

// File: tb/tb_global_branch_predictor.sv
// tb_global_branch_predictor
//   Self-checking bench for global_branch_predictor (PC_STEP = 1). A
//   behavioural model (BTB as an insertion-ordered queue, PHT as an int
//   array) predicts pcnext/clrbp every cycle; a directed sequence with
//   hand-computed values pins the model, then randomized traffic with
//   occasional resets follows.
module tb_global_branch_predictor;

  localparam int STEP = 1;
  localparam int HB   = 6;
  localparam int NB   = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  global_branch_predictor_if bif();

  global_branch_predictor #(
    .BTB_ENTRIES(NB),
    .HIST_BITS(HB),
    .PC_STEP(STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bp(bif.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

  // Model state
  btb_entry_t  m_btb[$];
  int          m_pht[1 << HB];
  int          m_ghr;
  bit          m_rec_valid;
  bit          m_rec_predt;
  logic [31:0] m_rec_target;
  int          m_rec_idx;

  // Values computed from the current inputs, reused at the next edge
  bit          exp_clrbp;
  logic [31:0] exp_pcnext;
  bit          f_predt;
  logic [31:0] f_target;
  int          f_idx;

  logic [31:0] prev_pc = 32'h0;

  function automatic int m_index(input logic [31:0] pc);
    int low;
    low = int'(pc[HB-1:0]);
`ifdef GBP_GSHARE_EN
    return low ^ m_ghr;
`else
    return low;
`endif
  endfunction

  function automatic int m_find(input logic [31:0] pc);
    for (int i = 0; i < m_btb.size(); i++) begin
      if (m_btb[i].tag == pc) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_btb.delete();
    for (int i = 0; i < (1 << HB); i++) m_pht[i] = 1;
    m_ghr        = 0;
    m_rec_valid  = 1'b0;
    m_rec_predt  = 1'b0;
    m_rec_target = '0;
    m_rec_idx    = 0;
  endtask

  task automatic modelEvaluate();
    bit          taken;
    int          s;
    logic [31:0] pred_pc;
    taken    = bif.pcsrcd[0] | bif.pcsrcd[1];
    s        = m_find(bif.originalpc);
    f_idx    = m_index(bif.originalpc);
    f_predt  = (s >= 0) && (m_pht[f_idx] >= 2);
    f_target = (s >= 0) ? m_btb[s].target : 32'h0;
    pred_pc  = f_predt ? f_target : bif.originalpc + 32'(STEP);
    exp_clrbp = m_rec_valid &&
                ((m_rec_predt != taken) ||
                 (taken && m_rec_predt && (m_rec_target != bif.pcbranchd)));
    if (exp_clrbp) exp_pcnext = taken ? bif.pcbranchd : bif.pcd + 32'(STEP);
    else           exp_pcnext = pred_pc;
  endtask

  task automatic modelAdvance();
    bit         taken;
    int         d;
    btb_entry_t e;
    taken = bif.pcsrcd[0] | bif.pcsrcd[1];
    d     = m_find(bif.pcd);
    if (m_rec_valid) begin
      if (taken) begin
        if (d >= 0) begin
          e = m_btb[d];
          e.target = bif.pcbranchd;
          m_btb[d] = e;
        end else begin
          e.tag    = bif.pcd;
          e.target = bif.pcbranchd;
          m_btb.push_back(e);
          if (m_btb.size() > NB) void'(m_btb.pop_front());
        end
      end
      if (taken || d >= 0) begin
        if (taken && m_pht[m_rec_idx] < 3)       m_pht[m_rec_idx]++;
        else if (!taken && m_pht[m_rec_idx] > 0) m_pht[m_rec_idx]--;
        m_ghr = ((m_ghr << 1) | int'(taken)) & ((1 << HB) - 1);
      end
    end
    m_rec_valid  = !exp_clrbp;
    m_rec_predt  = f_predt;
    m_rec_target = f_target;
    m_rec_idx    = f_idx;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one fetch cycle; pcd always follows the previous fetch PC
  task automatic applyStimulus(input logic [31:0] orig, input logic [1:0] src,
                               input logic [31:0] br, input bit rst_val);
    @(posedge clk);
    #2;
    reset          = rst_val;
    bif.pcd        = prev_pc;
    bif.originalpc = orig;
    bif.pcsrcd     = src;
    bif.pcbranchd  = br;
    prev_pc        = orig;
  endtask

  task automatic expectLiteral(input string name, input logic [31:0] next_exp,
                               input bit clr_exp);
    @(negedge clk);
    #1;
    checkOutput({name, "_pcnext"}, bif.pcnext, next_exp);
    checkOutput({name, "_clrbp"}, {31'b0, bif.clrbp}, {31'b0, clr_exp});
  endtask

  task automatic stepCheck(input string name, input logic [31:0] orig,
                           input logic [1:0] src, input logic [31:0] br,
                           input logic [31:0] next_exp, input bit clr_exp);
    applyStimulus(orig, src, br, 1'b0);
    expectLiteral(name, next_exp, clr_exp);
  endtask

  // Model comparison on every falling edge, model update on every rising edge
  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      if (reset) modelReset();
      modelEvaluate();
      checkOutput("model_pcnext", bif.pcnext, exp_pcnext);
      checkOutput("model_clrbp", {31'b0, bif.clrbp}, {31'b0, exp_clrbp});
      @(posedge clk);
      if (!reset) modelAdvance();
    end
  end

  // Directed sequence followed by randomized traffic
  initial begin
    logic [31:0] orig;
    logic [1:0]  src;
    logic [31:0] br;
    bit          rst_pick;

    bif.pcd        = '0;
    bif.originalpc = '0;
    bif.pcsrcd     = '0;
    bif.pcbranchd  = '0;
    repeat (3) @(posedge clk);

    stepCheck("seq1",   32'h1,  2'b00, 32'h0,  32'h2,  1'b0);
    stepCheck("seq2",   32'h2,  2'b00, 32'h0,  32'h3,  1'b0);
    stepCheck("seq3",   32'h3,  2'b00, 32'h0,  32'h4,  1'b0);
    stepCheck("alloc",  32'h7,  2'b01, 32'h50, 32'h50, 1'b1);
    stepCheck("squash", 32'h50, 2'b00, 32'h0,  32'h51, 1'b0);
    stepCheck("predT",  32'h3,  2'b00, 32'h0,  32'h50, 1'b0);
    stepCheck("predNT", 32'h4,  2'b00, 32'h0,  32'h4,  1'b1);
    stepCheck("after",  32'h9,  2'b00, 32'h0,  32'hA,  1'b0);
    stepCheck("weak",   32'h3,  2'b00, 32'h0,  32'h4,  1'b0);
    stepCheck("retrn",  32'h20, 2'b01, 32'h50, 32'h50, 1'b1);
    stepCheck("predT2", 32'h3,  2'b00, 32'h0,  32'h50, 1'b0);
    stepCheck("badtgt", 32'h50, 2'b01, 32'h10, 32'h10, 1'b1);
    stepCheck("sq2",    32'h11, 2'b00, 32'h0,  32'h12, 1'b0);
    stepCheck("newtgt", 32'h3,  2'b00, 32'h0,  32'h10, 1'b0);
    stepCheck("okjump", 32'h40, 2'b01, 32'h10, 32'h41, 1'b0);

    // Nine taken branches fill the BTB and push out 0x3 and 0x100
    for (int i = 0; i < 9; i++) begin
      stepCheck("fill_f", 32'h100 + 32'(i), 2'b00, 32'h0,
                32'h101 + 32'(i), 1'b0);
      stepCheck("fill_r", 32'h200, 2'b01, 32'h300 + 32'(i),
                32'h300 + 32'(i), 1'b1);
    end
    stepCheck("evicted", 32'h100, 2'b00, 32'h0, 32'h101, 1'b0);
    stepCheck("kept",    32'h108, 2'b00, 32'h0, 32'h308, 1'b0);

    // Reset in the middle of the stream wipes the trained state
    applyStimulus(32'h108, 2'b00, 32'h0, 1'b1);
    expectLiteral("inreset", 32'h109, 1'b0);
    applyStimulus(32'h108, 2'b01, 32'h999, 1'b0);
    expectLiteral("postrst", 32'h109, 1'b0);
    stepCheck("cold3", 32'h3, 2'b00, 32'h0, 32'h4, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) orig = 32'h3;
      else orig = 32'h100 + 32'($urandom_range(0, 11));
      src      = 2'($urandom_range(0, 3));
      br       = 32'h300 + 32'($urandom_range(0, 1));
      rst_pick = ($urandom_range(0, 249) == 0);
      applyStimulus(orig, src, br, rst_pick);
    end

    @(posedge clk);
    #2;
    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
